// File: rtl/packet_injector.sv
// Local-port transmitter: turns a core packet request into head/body/tail flits
// for the router local input, paced by a credit counter mirroring the router buffer.
module packet_injector #(
    parameter int unsigned ROUTER_ID = 0,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [3:0]  dest_i,
    input  logic [2:0]  len_i,
    output logic        req_ready_o,
    input  logic [14:0] pld_i,
    input  logic        pld_valid_i,
    output logic        pld_ready_o,
    input  logic        credit_i,
    output logic [16:0] flit_o,
    output logic        valid_o,
    output logic        err_o
);
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [3:0] SELF = 4'(ROUTER_ID);

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    state_t        state;
    logic [CW-1:0] credits;
    logic [3:0]    dest;
    logic [2:0]    len;
    logic [2:0]    count;

    logic        has_credit;
    logic        accept;
    logic        head_go;
    logic        body_go;
    logic        issue;
    logic        overflow;
    logic [3:0]  row_oh;
    logic [3:0]  col_oh;
    logic [16:0] head_flit;

    assign has_credit  = credits != '0;
    assign req_ready_o = state == IDLE;
    assign pld_ready_o = (state == BODY) && has_credit;
    assign accept      = req_i && req_ready_o;
    assign head_go     = (state == HEAD) && has_credit;
    assign body_go     = pld_valid_i && pld_ready_o;
    assign issue       = head_go || body_go;
    // A returned credit with nothing outstanding means the router and we disagree.
    assign overflow    = credit_i && (credits == FULL);

    assign row_oh    = 4'b0001 << dest[3:2];
    assign col_oh    = 4'b0001 << dest[1:0];
    assign head_flit = {(len == 3'd0) ? 2'b11 : 2'b10, SELF, len, row_oh, col_oh};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            credits <= FULL;
            dest    <= '0;
            len     <= '0;
            count   <= '0;
            flit_o  <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            valid_o <= issue;
            err_o   <= (accept && (dest_i == SELF)) || overflow;

            // Simultaneous issue and return cancel out.
            if (issue && !credit_i)
                credits <= credits - ONE;
            else if (credit_i && !issue && !overflow)
                credits <= credits + ONE;

            case (state)
                IDLE: begin
                    if (accept && (dest_i != SELF)) begin
                        dest  <= dest_i;
                        len   <= len_i;
                        state <= HEAD;
                    end
                end
                HEAD: begin
                    if (has_credit) begin
                        flit_o <= head_flit;
                        count  <= len;
                        state  <= (len == 3'd0) ? IDLE : BODY;
                    end
                end
                BODY: begin
                    if (body_go) begin
                        flit_o <= {(count == 3'd1) ? 2'b01 : 2'b00, pld_i};
                        count  <= count - 3'd1;
                        if (count == 3'd1)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_packet_injector.sv
// Directed plus randomized checks of packet_injector against a flit-list model.
module tb_packet_injector;
    localparam int BUF_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req = 1'b0;
    logic [3:0]  dest = '0;
    logic [2:0]  len = '0;
    logic        req_ready;
    logic [14:0] pld = '0;
    logic        pld_valid = 1'b0;
    logic        pld_ready;
    logic        man_cr = 1'b0;
    logic        auto_cr = 1'b0;
    logic        credit;
    logic [16:0] flit;
    logic        valid;
    logic        err;
    assign credit = man_cr | auto_cr;

    logic        req5 = 1'b0;
    logic [3:0]  dest5 = '0;
    logic [2:0]  len5 = '0;
    logic        rr5;
    logic [14:0] pld5 = '0;
    logic        pv5 = 1'b0;
    logic        pr5;
    logic        cr5 = 1'b0;
    logic [16:0] f5;
    logic        v5;
    logic        e5;

    packet_injector #(.ROUTER_ID(0), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .dest_i(dest), .len_i(len),
        .req_ready_o(req_ready), .pld_i(pld), .pld_valid_i(pld_valid),
        .pld_ready_o(pld_ready), .credit_i(credit), .flit_o(flit),
        .valid_o(valid), .err_o(err));

    packet_injector #(.ROUTER_ID(5), .BUF_DEPTH(BUF_DEPTH)) dut5 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req5), .dest_i(dest5), .len_i(len5),
        .req_ready_o(rr5), .pld_i(pld5), .pld_valid_i(pv5),
        .pld_ready_o(pr5), .credit_i(cr5), .flit_o(f5),
        .valid_o(v5), .err_o(e5));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Router side: collects flits, returns credits only for flits it holds.
    logic [16:0] got[$];
    int  fs = 0, cg = 0, maxout = 0, errs0 = 0;
    bit  auto_en = 1'b0;
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin fs = 0; cg = 0; end
        else if (credit) cg++;
        #1;
        if (valid) begin got.push_back(flit); fs++; end
        if (err) errs0++;
        if (fs - cg > maxout) maxout = fs - cg;
        auto_cr = auto_en && (fs - cg > 0) && ($urandom_range(3) != 0);
    end

    // Core side payload source with optional random gaps.
    logic [14:0] pq[$];
    int gap_pct = 0;
    bit fire = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (fire && pq.size() > 0) void'(pq.pop_front());
        if (pq.size() > 0 && $urandom_range(99) >= gap_pct) begin
            pld_valid = 1'b1;
            pld = pq[0];
        end else begin
            pld_valid = 1'b0;
        end
        fire = pld_valid && pld_ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] head_model(input int src, input int d, input int l);
        int v;
        v = (((l == 0) ? 3 : 2) << 15) | (src << 11) | (l << 8)
            | ((1 << (d / 4)) << 4) | (1 << (d % 4));
        return v[16:0];
    endfunction

    function automatic logic [16:0] body_model(input int p, input bit last);
        int v;
        v = (last ? (1 << 15) : 0) | p;
        return v[16:0];
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic send_req(input logic [3:0] d, input logic [2:0] l);
        bit rdy;
        rdy = 1'b0;
        req = 1'b1; dest = d; len = l;
        for (int k = 0; k < 500 && !rdy; k++) begin
            rdy = req_ready;
            tick();
        end
        req = 1'b0;
        chk("req_accept", {31'b0, rdy}, 1);
    endtask

    task automatic wait_flits(input int n, input int budget);
        for (int k = 0; k < budget && got.size() < n; k++) tick();
        chk("flit_count", got.size(), n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        auto_en = 1'b0;
        man_cr = 1'b0;
        tick(2);
        pq.delete();
        got.delete();
        rst_n = 1'b1;
        tick();
    endtask

    logic [16:0] exp_q[$];
    int pls[$];
    int exp_err;

    initial begin
        // Reset state
        tick(2);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_flit", flit, 0);
        chk("rst_err", err, 0);
        chk("rst_pld_ready", pld_ready, 0);
        chk("rst_credits", dut.credits, BUF_DEPTH);
        rst_n = 1'b1;
        tick();

        // Single head+tail flit
        send_req(4'd6, 3'd0);
        tick(3);
        wait_flits(1, 10);
        chk("ht_flit", got[0], 17'h18024);
        chk("ht_flit_model", got[0], head_model(0, 6, 0));
        chk("ht_valid_one_cycle", valid, 0);
        chk("ht_credits", dut.credits, 3);

        // Credit return in the same cycle as a flit issue
        req = 1'b1; dest = 4'd9; len = 3'd0;
        tick();
        req = 1'b0;
        man_cr = 1'b1;
        tick();
        man_cr = 1'b0;
        chk("same_cycle_valid", valid, 1);
        chk("same_cycle_credits", dut.credits, 3);
        chk("same_cycle_flit", flit, head_model(0, 9, 0));
        man_cr = 1'b1; tick(); man_cr = 1'b0; tick();
        chk("credit_return", dut.credits, 4);

        // Head/body/tail with fixed payloads
        got.delete();
        gap_pct = 0;
        pq.push_back(15'h1234);
        pq.push_back(15'h7FFF);
        send_req(4'd15, 3'd2);
        wait_flits(3, 50);
        chk("b2b_req_ready", req_ready, 1);
        chk("hbt_head", got[0], 17'h10288);
        chk("hbt_body", got[1], 17'h01234);
        chk("hbt_tail", got[2], 17'h0FFFF);
        do_reset();

        // Credit stall with len 7 and no returns
        exp_q.delete();
        pls.delete();
        for (int i = 0; i < 7; i++) begin
            pls.push_back($urandom_range(32767));
            pq.push_back(15'(pls[i]));
        end
        exp_q.push_back(head_model(0, 10, 7));
        for (int i = 0; i < 7; i++) exp_q.push_back(body_model(pls[i], i == 6));
        send_req(4'd10, 3'd7);
        tick(20);
        chk("stall_count", got.size(), 4);
        chk("stall_pld_ready", pld_ready, 0);
        chk("stall_valid", valid, 0);
        chk("stall_flit_hold", flit, exp_q[3]);
        man_cr = 1'b1; tick(); man_cr = 1'b0;
        tick(10);
        chk("one_credit_one_flit", got.size(), 5);
        auto_en = 1'b1;
        wait_flits(8, 200);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("stall_flit", got[i], exp_q[i]);
        auto_en = 1'b0;
        tick(10);

        // Reset mid-body
        do_reset();
        for (int i = 0; i < 7; i++) pq.push_back(15'(i));
        send_req(4'd3, 3'd7);
        wait_flits(2, 50);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_credits", dut.credits, 4);
        chk("midrst_pld_ready", pld_ready, 0);
        tick();
        pq.delete();
        rst_n = 1'b1;
        tick();
        got.delete();

        // Credit while counter is full
        man_cr = 1'b1; tick(); man_cr = 1'b0;
        chk("ovf_err", err, 1);
        chk("ovf_credits", dut.credits, 4);
        tick();
        chk("ovf_err_pulse", err, 0);

        // Self-destination drop on ROUTER_ID 5
        req5 = 1'b1; dest5 = 4'd5; len5 = 3'd3;
        tick();
        req5 = 1'b0;
        chk("self_err", e5, 1);
        chk("self_valid", v5, 0);
        chk("self_req_ready", rr5, 1);
        tick();
        chk("self_err_pulse", e5, 0);
        chk("self_no_flit", v5, 0);
        req5 = 1'b1; dest5 = 4'd0; len5 = 3'd0;
        tick();
        req5 = 1'b0;
        tick();
        chk("id5_valid", v5, 1);
        chk("id5_flit", f5, head_model(5, 0, 0));

        // Randomized traffic against the flit-list model
        do_reset();
        exp_q.delete();
        exp_err = 0;
        errs0 = 0;
        maxout = 0;
        gap_pct = 30;
        auto_en = 1'b1;
        for (int p = 0; p < 20; p++) begin
            int d, l;
            d = $urandom_range(15);
            l = $urandom_range(7);
            if (d == 0) begin
                exp_err++;
            end else begin
                exp_q.push_back(head_model(0, d, l));
                for (int i = 0; i < l; i++) begin
                    int w;
                    w = $urandom_range(32767);
                    pq.push_back(15'(w));
                    exp_q.push_back(body_model(w, i == l - 1));
                end
            end
            send_req(4'(d), 3'(l));
        end
        wait_flits(exp_q.size(), 3000);
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk("rand_flit", got[i], exp_q[i]);
        tick(3);
        chk("rand_errs", errs0, exp_err);
        chk("rand_credit_bound", {31'b0, maxout <= BUF_DEPTH}, 1);
        auto_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
